controle_irrigacao: RTL and testbench

CONTROLE_IRRIGACAO -- requirements
Module: controle_irrigacao

---
 rtl/controle_irrigacao.sv | 169 ++++++++++++++++
 tb/tb_controle_irrigacao.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/controle_irrigacao.sv
// Irrigation controller: filtered soil/tank sensors drive a sprinkler/drip/pause FSM.
// Optional blinking alarm in ERRO is enabled by defining CONTROLE_ALARME_EN.
//
// state         | meaning
// ST_OCIOSO     | idle, waiting for dry soil and usable tank level
// ST_ASPERSAO   | sprinkler irrigation requested from the timer
// ST_GOTEJAMENTO| drip irrigation requested from the timer
// ST_PAUSA      | rest period after an irrigation, counted in umSegundo ticks
// ST_ERRO       | filtered sensor value invalid
module controle_irrigacao #(
  parameter int FILTRO = 3,
  parameter int PAUSA  = 10
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       umSegundo,
  input  logic [1:0] umidadeSolo,
  input  logic [2:0] nivelDagua,
  input  logic       fimTempo,
  output logic       aspersao,
  output logic       gotejamento,
  output logic       valvulaEntrada,
  output logic       erroSensor,
  output logic       alarme,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    ST_OCIOSO      = 3'b000,
    ST_ASPERSAO    = 3'b001,
    ST_GOTEJAMENTO = 3'b010,
    ST_PAUSA       = 3'b011,
    ST_ERRO        = 3'b100
  } state_t;

  localparam logic [3:0] FILTRO_C = 4'(FILTRO);
  localparam logic [5:0] PAUSA_C  = 6'(PAUSA);

  state_t     state, state_nxt;
  logic [1:0] solo_raw, solo_f;
  logic [2:0] nivel_raw, nivel_f;
  logic [3:0] solo_cnt, solo_cnt_nxt, nivel_cnt, nivel_cnt_nxt;
  logic       solo_ok, nivel_ok, valido;
  logic       solo_inv, nivel_inv, valv_nxt;
  logic [5:0] pausa_cnt, pausa_cnt_nxt;

  // Count of consecutive equal samples, saturating at FILTRO; a changed sample restarts at 1.
  always_comb begin
    solo_cnt_nxt  = 4'd1;
    nivel_cnt_nxt = 4'd1;
    if (solo_cnt != 4'd0 && umidadeSolo == solo_raw)
      solo_cnt_nxt = (solo_cnt == FILTRO_C) ? solo_cnt : solo_cnt + 4'd1;
    if (nivel_cnt != 4'd0 && nivelDagua == nivel_raw)
      nivel_cnt_nxt = (nivel_cnt == FILTRO_C) ? nivel_cnt : nivel_cnt + 4'd1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      solo_raw  <= 2'b00;
      solo_f    <= 2'b00;
      solo_cnt  <= 4'd0;
      solo_ok   <= 1'b0;
      nivel_raw <= 3'b000;
      nivel_f   <= 3'b000;
      nivel_cnt <= 4'd0;
      nivel_ok  <= 1'b0;
    end else if (umSegundo) begin
      solo_raw  <= umidadeSolo;
      solo_cnt  <= solo_cnt_nxt;
      nivel_raw <= nivelDagua;
      nivel_cnt <= nivel_cnt_nxt;
      if (solo_cnt_nxt == FILTRO_C) begin
        solo_f  <= umidadeSolo;
        solo_ok <= 1'b1;
      end
      if (nivel_cnt_nxt == FILTRO_C) begin
        nivel_f  <= nivelDagua;
        nivel_ok <= 1'b1;
      end
    end
  end

  assign valido    = solo_ok & nivel_ok;
  assign solo_inv  = (solo_f == 2'b10);
  assign nivel_inv = !(nivel_f inside {3'b000, 3'b001, 3'b011, 3'b111});

  always_comb begin
    state_nxt = state;
    if (!valido)
      state_nxt = ST_OCIOSO;
    else if (solo_inv || nivel_inv)
      state_nxt = ST_ERRO;
    else begin
      case (state)
        ST_OCIOSO: begin
          if (solo_f == 2'b00 && nivel_f == 3'b111)
            state_nxt = ST_ASPERSAO;
          else if (solo_f == 2'b00 && (nivel_f == 3'b001 || nivel_f == 3'b011))
            state_nxt = ST_GOTEJAMENTO;
        end
        ST_ASPERSAO, ST_GOTEJAMENTO: begin
          if (fimTempo || solo_f == 2'b11 || nivel_f == 3'b000)
            state_nxt = ST_PAUSA;
        end
        ST_PAUSA: begin
          if (umSegundo && pausa_cnt <= 6'd1)
            state_nxt = ST_OCIOSO;
        end
        ST_ERRO:  state_nxt = ST_OCIOSO;
        default:  state_nxt = ST_OCIOSO;
      endcase
    end
  end

  // Inlet valve hysteresis: open on empty, close on full.
  always_comb begin
    valv_nxt = valvulaEntrada;
    if (!valido || state_nxt == ST_ERRO)
      valv_nxt = 1'b0;
    else if (nivel_f == 3'b000)
      valv_nxt = 1'b1;
    else if (nivel_f == 3'b111)
      valv_nxt = 1'b0;
  end

  always_comb begin
    pausa_cnt_nxt = pausa_cnt;
    if (state_nxt != ST_PAUSA)
      pausa_cnt_nxt = 6'd0;
    else if (state != ST_PAUSA)
      pausa_cnt_nxt = PAUSA_C;
    else if (umSegundo)
      pausa_cnt_nxt = pausa_cnt - 6'd1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state          <= ST_OCIOSO;
      pausa_cnt      <= 6'd0;
      aspersao       <= 1'b0;
      gotejamento    <= 1'b0;
      valvulaEntrada <= 1'b0;
      erroSensor     <= 1'b0;
    end else begin
      state          <= state_nxt;
      pausa_cnt      <= pausa_cnt_nxt;
      aspersao       <= (state_nxt == ST_ASPERSAO);
      gotejamento    <= (state_nxt == ST_GOTEJAMENTO);
      valvulaEntrada <= valv_nxt;
      erroSensor     <= (state_nxt == ST_ERRO);
    end
  end

  assign estado = state;

`ifdef CONTROLE_ALARME_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)
      alarme <= 1'b0;
    else if (state_nxt != ST_ERRO)
      alarme <= 1'b0;
    else if (state == ST_ERRO && umSegundo)
      alarme <= ~alarme;
  end
`else
  assign alarme = 1'b0;
`endif

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao; expected output words are queued as stimulus
// is applied and popped when the DUT outputs are sampled on the falling clock edge.
module tb_controle_irrigacao;

  logic       clock = 1'b0;
  logic       resetN;
  logic       umSegundo;
  logic [1:0] umidadeSolo;
  logic [2:0] nivelDagua;
  logic       fimTempo;
  logic       aspersao, gotejamento, valvulaEntrada, erroSensor, alarme;
  logic [2:0] estado;

  controle_irrigacao #(.FILTRO(3), .PAUSA(10)) dut (
    .clock          (clock),
    .resetN         (resetN),
    .umSegundo      (umSegundo),
    .umidadeSolo    (umidadeSolo),
    .nivelDagua     (nivelDagua),
    .fimTempo       (fimTempo),
    .aspersao       (aspersao),
    .gotejamento    (gotejamento),
    .valvulaEntrada (valvulaEntrada),
    .erroSensor     (erroSensor),
    .alarme         (alarme),
    .estado         (estado)
  );

  always #5 clock = ~clock;

  // {estado, aspersao, gotejamento, valvulaEntrada, erroSensor, alarme}
  localparam logic [7:0] IDLE  = 8'b000_00000;
  localparam logic [7:0] ASP   = 8'b001_10000;
  localparam logic [7:0] GOT   = 8'b010_01000;
  localparam logic [7:0] PAU   = 8'b011_00000;
  localparam logic [7:0] PAU_V = 8'b011_00100;
  localparam logic [7:0] ERR   = 8'b100_00010;
`ifdef CONTROLE_ALARME_EN
  localparam logic [7:0] ALM   = 8'b000_00001;
`else
  localparam logic [7:0] ALM   = 8'b000_00000;
`endif

  logic [7:0] obs;
  assign obs = {estado, aspersao, gotejamento, valvulaEntrada, erroSensor, alarme};

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic expect_out(input string t, input logic [7:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check_out();
    logic [7:0] e;
    string      t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: observed=%b expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed=%b expected=%b", t, obs, e);
      end
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      @(negedge clock) umSegundo = 1'b1;
      @(negedge clock) umSegundo = 1'b0;
    end
  endtask

  task automatic pulse_fim();
    @(negedge clock) fimTempo = 1'b1;
    @(negedge clock) fimTempo = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; umSegundo = 1'b0; fimTempo = 1'b0;
    umidadeSolo = 2'b00; nivelDagua = 3'b111;
    clk_n(2);
    expect_out("reset", IDLE); check_out();
    resetN = 1'b1;

    // dry soil, full tank: sprinkler after the third tick plus one clock
    expect_out("filter_2ticks", IDLE);   do_tick(2); check_out();
    expect_out("filter_3rd_tick", IDLE); do_tick(1); check_out();
    expect_out("asp_entry", ASP);        clk_n(1);   check_out();

    // timer expiry, pause of 10 ticks, re-entry
    expect_out("fim_to_pausa", PAU);   pulse_fim(); check_out();
    expect_out("pausa_9ticks", PAU);   do_tick(9);  check_out();
    expect_out("pausa_10ticks", IDLE); do_tick(1);  check_out();
    expect_out("reenter_asp", ASP);    clk_n(1);    check_out();

    // asynchronous reset in the middle of ASPERSAO
    #3 resetN = 1'b0;
    #1 expect_out("async_reset", IDLE); check_out();
    @(negedge clock) resetN = 1'b1;
    expect_out("post_reset_3ticks", IDLE); do_tick(3); check_out();
    expect_out("post_reset_resume", ASP);  clk_n(1);   check_out();

    // level drops to medio during pause -> drip mode afterwards
    expect_out("fim_to_pausa_2", PAU); pulse_fim(); nivelDagua = 3'b011; check_out();
    expect_out("pausa_end_2", IDLE);   do_tick(10); check_out();
    expect_out("got_entry", GOT);      clk_n(1);    check_out();

    // tank empties: abort to pause, inlet valve opens and holds until full accepted
    nivelDagua = 3'b000;
    expect_out("got_before_accept", GOT); do_tick(3); check_out();
    expect_out("abort_to_pausa", PAU_V);  clk_n(1);   check_out();
    nivelDagua = 3'b001; do_tick(3);
    nivelDagua = 3'b011;
    expect_out("valve_hold_011", PAU_V);  do_tick(3); check_out();
    nivelDagua = 3'b111;
    expect_out("valve_hold_until_accept", PAU_V); do_tick(3); check_out();
    expect_out("valve_clear", PAU);       clk_n(1);   check_out();
    expect_out("pausa_end_3", IDLE);      do_tick(1); check_out();
    expect_out("asp_again", ASP);         clk_n(1);   check_out();

    // short glitch on the level sensor is filtered out
    nivelDagua = 3'b011; do_tick(2);
    expect_out("glitch_during", ASP); check_out();
    nivelDagua = 3'b111;
    expect_out("glitch_ignored", ASP); do_tick(3); clk_n(1); check_out();

    // invalid level code -> ERRO with blinking alarm, recovery on valid level
    nivelDagua = 3'b101;
    expect_out("err_before", ASP);              do_tick(3); check_out();
    expect_out("err_entry", ERR);               clk_n(1);   check_out();
    expect_out("alarm_tick1", ERR | ALM);       do_tick(1); check_out();
    expect_out("alarm_tick2", ERR);             do_tick(1); check_out();
    nivelDagua = 3'b111;
    expect_out("err_recover_tick", ERR | ALM);  do_tick(3); check_out();
    expect_out("err_exit", IDLE);               clk_n(1);   check_out();
    expect_out("asp_after_err", ASP);           clk_n(1);   check_out();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
